u_32b_sub_seq: RTL and testbench

U_32B_SUB_SEQ -- requirements
Module: u_32b_sub_seq

---
 rtl/u_32b_sub_seq.sv | 99 +++++++++
 tb/tb_u_32b_sub_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/u_32b_sub_seq.sv
// ----------------------------------------------------------------------------
// u_32b_sub_seq : 32-bit subtractor, one 4-bit nibble per cycle, LSB first.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module u_32b_sub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic [31:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_k;
  logic        r_brw;

  logic [3:0]  w_an;
  logic [3:0]  w_bn;
  logic [3:0]  w_dn;
  logic [4:0]  w_br;

  assign w_an    = r_a[{r_k, 2'b00} +: 4];
  assign w_bn    = r_b[{r_k, 2'b00} +: 4];
  assign w_br[0] = r_brw;

  // w_br[i] is the borrow into bit i of the current nibble
  for (genvar i = 0; i < 4; i++) begin : g_fs
    assign w_dn[i]   = w_an[i] ^ w_bn[i] ^ w_br[i];
    assign w_br[i+1] = (~w_an[i] & w_bn[i]) | (~(w_an[i] ^ w_bn[i]) & w_br[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_k     <= 3'd0;
      r_brw   <= 1'b0;
      diff    <= 32'd0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          diff[{r_k, 2'b00} +: 4] <= w_dn;
          r_brw <= w_br[4];
          r_k   <= r_k + 3'd1;
          if (r_k == 3'd7) begin
            // top nibble: borrow into bit 31 is w_br[3], out of bit 31 is w_br[4]
            bout    <= w_br[4];
            ovf     <= w_br[3] ^ w_br[4];
            zero    <= ({w_dn, diff[27:0]} == 32'd0);
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_brw   <= bin;
            r_k     <= 3'd0;
            diff    <= 32'd0;
            r_state <= S_RUN;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_u_32b_sub_seq.sv
// ----------------------------------------------------------------------------
// tb_u_32b_sub_seq : randomized and directed checks of u_32b_sub_seq.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_u_32b_sub_seq;

  localparam longint C_SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint C_SMIN = -64'sh0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;

  u_32b_sub_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit and signed 64-bit arithmetic.
  task automatic model(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                       output logic [31:0] ed, output logic eb, output logic eo,
                       output logic ez);
    logic [32:0] r;
    longint      s;
    r  = {1'b0, ta} - {1'b0, tb_} - {32'd0, tbin};
    ed = r[31:0];
    eb = r[32];
    s  = longint'($signed(ta)) - longint'($signed(tb_)) - longint'({63'd0, tbin});
    eo = (s > C_SMAX) || (s < C_SMIN);
    ez = (ed == 32'd0);
  endtask

  // One operation from a negedge. inj>0 pulses start with junk operands in RUN
  // cycle inj; chain holds start through DONE with the next operands.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                        input int inj, input bit chain, input logic [31:0] na,
                        input logic [31:0] nb, input logic nbin, input bit predriven);
    logic [31:0] ed;
    logic [31:0] m;
    logic        eb, eo, ez;
    model(ta, tb_, tbin, ed, eb, eo, ez);
    if (!predriven) begin
      start = 1'b1; a = ta; b = tb_; bin = tbin;
    end
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        m = 32'hFFFF_FFFF >> (32 - 4 * (n - 1));
        if (n == 1) m = 32'd0;
        check("busy_run", {63'd0, busy}, 64'd1);
        check("done_run", {63'd0, done}, 64'd0);
        check("diff_partial", {32'd0, diff}, {32'd0, ed & m});
      end else begin
        check("done_pulse", {63'd0, done}, 64'd1);
        check("busy_done", {63'd0, busy}, 64'd0);
        check("diff", {32'd0, diff}, {32'd0, ed});
        check("bout", {63'd0, bout}, {63'd0, eb});
        check("ovf", {63'd0, ovf}, {63'd0, eo});
        check("zero", {63'd0, zero}, {63'd0, ez});
        if (chain) begin
          start = 1'b1; a = na; b = nb; bin = nbin;
        end
      end
      if (inj > 0 && n == inj) begin
        start = 1'b1; a = $urandom; b = $urandom; bin = 1'($urandom);
      end
      if (inj > 0 && n == inj + 1) start = 1'b0;
    end
    if (!chain) begin
      @(negedge clk);
      check("done_once", {63'd0, done}, 64'd0);
      check("busy_idle", {63'd0, busy}, 64'd0);
      check("diff_hold", {32'd0, diff}, {32'd0, ed});
      check("bout_hold", {63'd0, bout}, {63'd0, eb});
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    start = 1'b0;
    a = 32'd0; b = 32'd0; bin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_diff", {32'd0, diff}, 64'd0);
    check("rst_flags", {58'd0, bout, ovf, zero, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed corner cases
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 0, 0, 0, 0, 0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 0, 0, 0, 0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 0, 0, 0, 0, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 0, 0, 0);
    run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 0, 0, 0, 0, 0, 0);
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, 0, 0, 0);

    // start in RUN is ignored
    run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 3, 0, 0, 0, 0, 0);

    // back-to-back through DONE
    run_op(32'hA5A5_0000, 32'h5A5A_0001, 1'b1, 0, 1, 32'h0000_0010, 32'h0000_0020, 1'b0, 0);
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 0, 0, 0, 0, 0, 1);

    // reset in RUN cycle 4 aborts
    start = 1'b1; a = 32'hFFFF_0000; b = 32'h0000_FFFF; bin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_diff", {32'd0, diff}, 64'd0);
    check("abort_flags", {58'd0, bout, ovf, zero, busy, done}, 64'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", {62'd0, busy, done}, 64'd0);
    end

    // randomized operations
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      run_op(ra, rb, 1'($urandom), 0, 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
